// File: rtl/knight_action_ctrl.sv
// knight_action_ctrl: per-frame action scheduler for the Knight player.
// Decodes the active keycode, sequences jump/fall/attack/cooldown and issues
// one registered motion command per frame (1 frame keycode-to-output latency).
// Optional attack input buffer: define KNIGHT_ATTACK_BUFFER_EN to enable it.
module knight_action_ctrl #(
    parameter int JUMP_FRAMES     = 27,
    parameter int ATTACK_FRAMES   = 12,
    parameter int HIT_START       = 3,
    parameter int HIT_END         = 8,
    parameter int COOLDOWN_FRAMES = 20,
    parameter int BUFFER_FRAMES   = 6
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    input  logic       grounded,
    output logic [1:0] x_cmd,
    output logic [1:0] y_cmd,
    output logic [3:0] status,
    output logic       inverse,
    output logic       hitbox_valid,
    output logic       cooldown_busy
);

    localparam logic [7:0] KEY_LEFT   = 8'h50;
    localparam logic [7:0] KEY_RIGHT  = 8'h4F;
    localparam logic [7:0] KEY_DOWN   = 8'h51;
    localparam logic [7:0] KEY_JUMP   = 8'h52;
    localparam logic [7:0] KEY_ATTACK = 8'h1B;

    localparam logic [1:0] X_NONE  = 2'b00;
    localparam logic [1:0] X_RIGHT = 2'b01;
    localparam logic [1:0] X_LEFT  = 2'b10;
    localparam logic [1:0] Y_NONE  = 2'b00;
    localparam logic [1:0] Y_UP    = 2'b01;
    localparam logic [1:0] Y_DOWN  = 2'b10;
    localparam logic [1:0] Y_FAST  = 2'b11;

    localparam int JW = $clog2(JUMP_FRAMES) + 1;
    localparam int AW = $clog2(ATTACK_FRAMES) + 1;
    localparam int CW = $clog2(COOLDOWN_FRAMES) + 1;

    localparam logic [JW-1:0] JCNT_LAST = JW'(JUMP_FRAMES - 1);
    localparam logic [AW-1:0] ACNT_LAST = AW'(ATTACK_FRAMES - 1);
    localparam logic [AW-1:0] HIT_LO    = AW'(HIT_START);
    localparam logic [AW-1:0] HIT_HI    = AW'(HIT_END);
    localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN_FRAMES);

    // Encoding equals the status code driven to the sprite logic.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WALK   = 3'd1,
        ST_JUMP   = 3'd2,
        ST_FALL   = 3'd3,
        ST_ATTACK = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [JW-1:0] jcnt, jcnt_nxt;
    logic [AW-1:0] acnt, acnt_nxt;
    logic [CW-1:0] cool, cool_nxt;
    logic [7:0]    key_prev;

    logic [1:0] x_nxt, y_nxt;
    logic       inv_nxt, hit_nxt;

    logic       is_left, is_right, is_dir;
    logic [1:0] dir_x;
    logic       jump_edge, atk_edge;
    logic       atk_ok, atk_go, buf_armed;

    assign is_left   = (keycode == KEY_LEFT);
    assign is_right  = (keycode == KEY_RIGHT);
    assign is_dir    = is_left || is_right;
    assign dir_x     = is_left ? X_LEFT : (is_right ? X_RIGHT : X_NONE);
    assign jump_edge = (keycode == KEY_JUMP)   && (key_prev != KEY_JUMP);
    assign atk_edge  = (keycode == KEY_ATTACK) && (key_prev != KEY_ATTACK);

    // An attack starts on a fresh press (or a buffered one) once cooled down.
    assign atk_ok = (cool == '0) && (state != ST_ATTACK);
    assign atk_go = atk_ok && (atk_edge || buf_armed);

`ifdef KNIGHT_ATTACK_BUFFER_EN
    localparam int BW = $clog2(BUFFER_FRAMES) + 1;

    logic [BW-1:0] atk_buf;

    assign buf_armed = (atk_buf != '0);

    // Buffer arms on a rejected press, clears when consumed, else counts down.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n)
            atk_buf <= '0;
        else if (atk_go)
            atk_buf <= '0;
        else if (atk_edge)
            atk_buf <= BW'(BUFFER_FRAMES);
        else if (buf_armed)
            atk_buf <= atk_buf - 1'b1;
    end
`else
    // Without the buffer a rejected press is simply dropped.
    assign buf_armed = 1'b0 & (BUFFER_FRAMES != 0);
`endif

    // Next state, counters and the outputs belonging to the next state.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_nxt = state;
        jcnt_nxt  = '0;
        acnt_nxt  = '0;
        cool_nxt  = cool;
        x_nxt     = X_NONE;
        y_nxt     = Y_NONE;
        inv_nxt   = inverse;
        hit_nxt   = 1'b0;

        case (state)
            ST_IDLE, ST_WALK: begin
                if (atk_go)
                    state_nxt = ST_ATTACK;
                else if (jump_edge && grounded)
                    state_nxt = ST_JUMP;
                else if (!grounded)
                    state_nxt = ST_FALL;
                else
                    state_nxt = is_dir ? ST_WALK : ST_IDLE;
            end
            ST_JUMP: begin
                if (atk_go)
                    state_nxt = ST_ATTACK;
                else if ((keycode != KEY_JUMP) || (jcnt == JCNT_LAST))
                    state_nxt = ST_FALL;
            end
            ST_FALL: begin
                if (atk_go)
                    state_nxt = ST_ATTACK;
                else if (grounded)
                    state_nxt = is_dir ? ST_WALK : ST_IDLE;
            end
            ST_ATTACK: begin
                if (acnt == ACNT_LAST)
                    state_nxt = grounded ? ST_IDLE : ST_FALL;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Frame counters restart at 0 on every entry into their state.
        if (state == ST_JUMP && state_nxt == ST_JUMP)
            jcnt_nxt = jcnt + 1'b1;
        if (state == ST_ATTACK && state_nxt == ST_ATTACK)
            acnt_nxt = acnt + 1'b1;

        // Cooldown loads as the attack ends and drains while not attacking.
        if (state == ST_ATTACK) begin
            if (acnt == ACNT_LAST)
                cool_nxt = COOL_LOAD;
        end else if (cool != '0) begin
            cool_nxt = cool - 1'b1;
        end

        // Facing follows direction keys except while attacking.
        if (state_nxt != ST_ATTACK) begin
            if (is_left)
                inv_nxt = 1'b1;
            else if (is_right)
                inv_nxt = 1'b0;
        end

        case (state_nxt)
            ST_WALK: x_nxt = dir_x;
            ST_JUMP: begin
                x_nxt = dir_x;
                y_nxt = Y_UP;
            end
            ST_FALL: begin
                x_nxt = dir_x;
                y_nxt = (keycode == KEY_DOWN) ? Y_FAST : Y_DOWN;
            end
            ST_ATTACK: begin
                x_nxt   = grounded ? X_NONE : dir_x;
                y_nxt   = grounded ? Y_NONE : Y_DOWN;
                hit_nxt = (acnt_nxt >= HIT_LO) && (acnt_nxt <= HIT_HI);
            end
            default: ;
        endcase
    end

    // State, counters and registered outputs; reset aborts any action.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= ST_IDLE;
            jcnt          <= '0;
            acnt          <= '0;
            cool          <= '0;
            key_prev      <= 8'h00;
            x_cmd         <= X_NONE;
            y_cmd         <= Y_NONE;
            status        <= 4'd0;
            inverse       <= 1'b0;
            hitbox_valid  <= 1'b0;
            cooldown_busy <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state         <= state_nxt;
            jcnt          <= jcnt_nxt;
            acnt          <= acnt_nxt;
            cool          <= cool_nxt;
            key_prev      <= keycode;
            x_cmd         <= x_nxt;
            y_cmd         <= y_nxt;
            status        <= {1'b0, state_nxt};
            inverse       <= inv_nxt;
            hitbox_valid  <= hit_nxt;
            cooldown_busy <= (cool_nxt != '0);
        end
    end

endmodule
